// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_fsm
//  Description : Top-level game-flow controller. Sequences the system through
//                the title, playing, paused, won and game-over screens from
//                debounced player keys and the game-logic win/lose flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl_fsm #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iKey_up,
  input  logic       iKey_down,
  input  logic       iKey_left,
  input  logic       iKey_right,
  input  logic       iGame_won,
  input  logic       iGame_over,
  output logic [2:0] oState,
  output logic       oPlaying,
  output logic       oNew_game
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    WON   = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_MAX = 16'(HOLD_CYCLES);

  state_t      state;
  state_t      next_state;
  logic        new_game_next;
  logic [3:0]  keys;
  logic [3:0]  prev_keys;
  logic [3:0]  press;
  logic        any_press;
  logic        chord;
  logic        prev_chord;
  logic        chord_press;
  logic [15:0] hold_cnt;
  logic        hold_done;
  logic        enter_end_screen;

  assign keys        = {iKey_up, iKey_down, iKey_left, iKey_right};
  assign press       = keys & ~prev_keys;
  assign any_press   = |press;
  assign chord       = iKey_left & iKey_right;
  assign chord_press = chord & ~prev_chord;
  assign hold_done   = (hold_cnt == HOLD_MAX);

  // Entering WON/OVER from another state restarts the hold timer.
  assign enter_end_screen = ((next_state == WON) || (next_state == OVER)) &&
                            (next_state != state);

  // Key history; reset to all ones so keys held through reset are not presses.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      prev_keys  <= 4'hF;
      prev_chord <= 1'b1;
    end else begin
      prev_keys  <= keys;
      prev_chord <= chord;
    end
  end

  // State register with registered status outputs kept in step with it.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      oPlaying  <= 1'b0;
      oNew_game <= 1'b0;
    end else begin
      state     <= next_state;
      oPlaying  <= (next_state == PLAY);
      oNew_game <= new_game_next;
    end
  end

  // Hold timer for the end screens: cleared on entry, saturates at HOLD_MAX.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hold_cnt <= 16'd0;
    end else if (enter_end_screen) begin
      hold_cnt <= 16'd0;
    end else if ((state == WON) || (state == OVER)) begin
      if (!hold_done) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

  // Next-state decode; new-game pulse only on the IDLE->PLAY step.
  always_comb begin
    next_state    = state;
    new_game_next = 1'b0;
    case (state)
      IDLE: begin
        if (any_press) begin
          next_state    = PLAY;
          new_game_next = 1'b1;
        end
      end
      PLAY: begin
        if (iGame_over) begin
          next_state = OVER;
        end else if (iGame_won) begin
          next_state = WON;
        end else if (chord_press) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (chord_press) begin
          next_state = PLAY;
        end
      end
      WON, OVER: begin
        if (hold_done && any_press) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign oState = state;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl_fsm
//  Description : Self-checking bench for game_ctrl_fsm: directed scenarios
//                followed by random traffic, compared against a screen-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl_fsm;

  localparam int HOLD = 4;

  // Screen codes as seen on the state output
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_WON   = 3;
  localparam int M_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       game_won = 1'b0, game_over = 1'b0;
  logic [2:0] state;
  logic       playing;
  logic       new_game;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         m_screen = M_IDLE;
  bit         m_play = 0;
  bit         m_new = 0;
  int         m_dwell = 0;      // cycles spent on the current end screen
  bit [3:0]   m_last_keys = 4'hF;
  bit         m_last_chord = 1;

  game_ctrl_fsm #(.HOLD_CYCLES(HOLD)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iKey_up   (key_up),
    .iKey_down (key_down),
    .iKey_left (key_left),
    .iKey_right(key_right),
    .iGame_won (game_won),
    .iGame_over(game_over),
    .oState    (state),
    .oPlaying  (playing),
    .oNew_game (new_game)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit [3:0] k, input bit w, input bit o);
    bit fresh;
    bit chord_now;
    bit chord_edge;
    int nxt;
    if (r) begin
      m_screen = M_IDLE; m_play = 0; m_new = 0; m_dwell = 0;
      m_last_keys = 4'hF; m_last_chord = 1;
      return;
    end
    fresh      = ((k & ~m_last_keys) != 4'h0);
    chord_now  = k[1] & k[0];
    chord_edge = chord_now & ~m_last_chord;
    nxt   = m_screen;
    m_new = 0;
    if (m_screen == M_IDLE) begin
      if (fresh) begin nxt = M_PLAY; m_new = 1; end
    end else if (m_screen == M_PLAY) begin
      if (o) nxt = M_OVER;
      else if (w) nxt = M_WON;
      else if (chord_edge) nxt = M_PAUSE;
    end else if (m_screen == M_PAUSE) begin
      if (chord_edge) nxt = M_PLAY;
    end else begin
      if (m_dwell >= HOLD && fresh) nxt = M_IDLE;
    end
    if ((nxt == M_WON || nxt == M_OVER) && nxt != m_screen) m_dwell = 0;
    else m_dwell++;
    m_screen     = nxt;
    m_play       = (nxt == M_PLAY);
    m_last_keys  = k;
    m_last_chord = chord_now;
  endtask

  // k = {up, down, left, right}
  task automatic step(input bit r, input bit [3:0] k, input bit w, input bit o);
    rst = r;
    {key_up, key_down, key_left, key_right} = k;
    game_won = w;
    game_over = o;
    @(posedge clk);
    model_edge(r, k, w, o);
    #1;
    check("state",    int'(state),    m_screen);
    check("playing",  int'(playing),  int'(m_play));
    check("new_game", int'(new_game), int'(m_new));
  endtask

  localparam bit [3:0] K_NONE  = 4'b0000;
  localparam bit [3:0] K_UP    = 4'b1000;
  localparam bit [3:0] K_RIGHT = 4'b0001;
  localparam bit [3:0] K_CHORD = 4'b0011;

  initial begin
    // Reset then idle
    step(1, K_NONE, 0, 0);
    check("reset_state", int'(state), M_IDLE);
    for (int i = 0; i < 10; i++) step(0, K_NONE, 0, 0);
    check("idle_state", int'(state), M_IDLE);

    // Start a game with a right-key pulse, then hold right
    step(0, K_RIGHT, 0, 0);
    check("start_state", int'(state), M_PLAY);
    check("start_pulse", int'(new_game), 1);
    for (int i = 0; i < 5; i++) step(0, K_RIGHT, 0, 0);
    check("held_state", int'(state), M_PLAY);
    check("held_pulse", int'(new_game), 0);
    step(0, K_NONE, 0, 0);

    // Game over, early press ignored, later press returns to title
    for (int i = 0; i < 3; i++) step(0, K_NONE, 0, 1);
    check("over_state", int'(state), M_OVER);
    check("over_playing", int'(playing), 0);
    step(0, K_UP, 0, 0);
    check("early_press", int'(state), M_OVER);
    for (int i = 0; i < 4; i++) step(0, K_NONE, 0, 0);
    step(0, K_UP, 0, 0);
    check("late_press", int'(state), M_IDLE);
    step(0, K_NONE, 0, 0);

    // Both flags: over wins
    step(0, K_RIGHT, 0, 0);
    step(0, K_NONE, 1, 1);
    check("both_flags", int'(state), M_OVER);
    for (int i = 0; i < 5; i++) step(0, K_NONE, 0, 0);
    step(0, K_UP, 0, 0);
    step(0, K_NONE, 0, 0);
    // Won only
    step(0, K_RIGHT, 0, 0);
    step(0, K_NONE, 1, 0);
    check("won_state", int'(state), M_WON);
    for (int i = 0; i < 5; i++) step(0, K_NONE, 0, 0);
    step(0, K_UP, 0, 0);
    check("won_exit", int'(state), M_IDLE);
    step(0, K_NONE, 0, 0);

    // Pause / resume
    step(0, K_UP, 0, 0);
    step(0, K_NONE, 0, 0);
    step(0, K_CHORD, 0, 0);
    check("pause_state", int'(state), M_PAUSE);
    step(0, K_CHORD, 0, 1);
    check("pause_ignores_over", int'(state), M_PAUSE);
    step(0, K_NONE, 0, 0);
    step(0, K_CHORD, 0, 0);
    check("resume_state", int'(state), M_PLAY);
    check("resume_no_pulse", int'(new_game), 0);
    step(0, K_NONE, 0, 0);

    // Reset from pause with a key held through it
    step(0, K_CHORD, 0, 0);
    step(1, K_RIGHT, 0, 0);
    check("rst_pause", int'(state), M_IDLE);
    step(0, K_RIGHT, 0, 0);
    check("held_through_rst", int'(state), M_IDLE);
    step(0, K_NONE, 0, 0);
    step(0, K_RIGHT, 0, 0);
    check("fresh_after_rst", int'(state), M_PLAY);

    // Reset from WON
    step(0, K_NONE, 1, 0);
    step(1, K_NONE, 0, 0);
    check("rst_won", int'(state), M_IDLE);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] k;
      k[3] = ($urandom_range(0, 3) == 0);
      k[2] = ($urandom_range(0, 3) == 0);
      k[1] = ($urandom_range(0, 2) == 0);
      k[0] = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 199) == 0), k,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Top-level game-flow controller: sequences the system through title, playing, paused, won and game-over screens.
- Inputs are player keys (already synchronised and debounced upstream) and win/lose flags from the game-logic block.
- Drives a 3-bit state code consumed by the video/render and game-logic blocks, plus a playing enable and a new-game pulse.

Parameters:
- HOLD_CYCLES, 100, minimum number of clocks the WON/OVER screens are held before a key press is accepted (range 1..2^16-1).

Ports:
- iClk  input  1  system clock (50 MHz); all logic on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iKey_up  input  1  up key, level, active-high.
- iKey_down  input  1  down key, level, active-high.
- iKey_left  input  1  left key, level, active-high.
- iKey_right  input  1  right key, level, active-high.
- iGame_won  input  1  level from game logic: win condition reached.
- iGame_over  input  1  level from game logic: lose condition reached.
- oState  output  3  registered current state code.
- oPlaying  output  1  registered; 1 exactly when oState==PLAY.
- oNew_game  output  1  registered one-cycle pulse on every IDLE->PLAY transition; used as the game-logic reset.

Behaviour:
- State encoding on oState:
  - IDLE=3'd0
  - PLAY=3'd1
  - PAUSE=3'd2
  - WON=3'd3
  - OVER=3'd4
  - Codes 5..7 are illegal.
- Reset (iRst=1 at a rising edge):
  - oState=IDLE, oPlaying=0, oNew_game=0, hold counter=0.
  - Key-history registers are set to all ones, so a key already held through reset is not counted as a press.
  - Reset has priority over all other inputs at any time, including mid-game.
- Key edge detection:
  - prev_k is the registered previous value of each key.
  - press_k = key & ~prev_k, computed combinationally from the current input.
  - any_press = OR of the four press signals.
  - chord = iKey_left & iKey_right; chord_press is the rising edge of chord, using the registered previous chord value.
- Next-state logic is combinational from the current state and inputs; the state register updates on the next edge, so the response appears one clock after the inputs are sampled.
- Transitions, evaluated each cycle:
  - IDLE: any_press -> PLAY and assert oNew_game for that one cycle. iGame_won/iGame_over are ignored.
  - PLAY, in priority order:
    - iGame_over=1 -> OVER (over wins if both flags are high).
    - else iGame_won=1 -> WON.
    - else chord_press -> PAUSE.
    - else stay.
  - PAUSE: chord_press -> PLAY, with no oNew_game pulse. iGame_won/iGame_over are ignored while paused.
  - WON and OVER:
    - Hold counter clears to 0 on entry, then increments each cycle, saturating at HOLD_CYCLES.
    - When counter==HOLD_CYCLES and any_press occurs -> IDLE.
    - Presses before that are discarded; they are not queued.
  - Illegal codes 5..7 -> IDLE on the next clock.
- oNew_game is 1 only in the first cycle oState==PLAY after IDLE; it is 0 otherwise.
- oPlaying is registered in step with oState (no extra latency).
- Hold counter is 16 bits and is not used outside WON/OVER.

Test Plan:
- Reset, then hold all inputs 0 for 10 clocks -> oState=0, oPlaying=0, oNew_game=0 throughout.
- From IDLE, pulse iKey_right for 1 clock -> oState=1 on the next edge, oNew_game=1 for exactly 1 cycle, oPlaying=1. Hold iKey_right high for 5 more clocks -> no further transitions.
- In PLAY, raise iGame_over for 3 clocks -> oState=4, oPlaying=0. Lower it, with HOLD_CYCLES=4:
  - a key press 2 cycles after entry is ignored;
  - a press after 4+ cycles -> oState=0.
- In PLAY, raise iGame_won and iGame_over in the same cycle -> oState=4 (over priority). Repeat with only iGame_won -> oState=3.
- In PLAY, raise iKey_left and iKey_right together -> oState=2. Raise iGame_over while paused -> stays 2. Release, then press the chord again -> oState=1 with oNew_game=0.
- Assert iRst for 1 clock while in PAUSE or WON -> oState=0 on the next edge. A key held through reset does not start a game; a fresh press does.
